// File: rtl/alu_cmd_issuer.sv
// Command-side initiator for a combinational ALU: accepts a command, drives the ALU,
// waits for the outputs to settle, captures them and returns a response. Owns the carry flag.
module alu_cmd_issuer #(
   parameter int unsigned WIDTH         = 32,
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [3:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   input  logic [1:0]       cmd_cin_sel,
   input  logic             flag_clr,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_op,
   output logic             alu_cin,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_cout,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_carry,
   output logic             rsp_zero,
   output logic             carry_flag
);

   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;

   logic [1:0]       state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             accept_c;
   logic             capture_c;
   logic             cin_c;
   logic             arith_c;

   // Carry-in resolution; the flag value seen here is the one at the accept edge
   always_comb begin
      cin_c = 1'b0;
      case (cmd_cin_sel)
         2'd1:    cin_c = 1'b1;
         2'd2:    cin_c = carry_flag;
         default: cin_c = 1'b0;
      endcase
   end

   // Only add/sub produce a meaningful carry; alu_op holds the in-flight command
   assign arith_c = (alu_op == OP_ADD) || (alu_op == OP_SUB);

   // Next-state logic
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      accept_c  = 1'b0;
      capture_c = 1'b0;
      case (state)
         S_IDLE: begin
            if (cmd_valid && cmd_ready) begin
               accept_c  = 1'b1;
               state_nxt = S_WAIT;
               cnt_nxt   = '0;
            end
         end
         S_WAIT: begin
            if (cnt == CNT_LAST) begin
               capture_c = 1'b1;
               state_nxt = S_RESP;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         S_RESP: begin
            if (rsp_valid && rsp_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // State register; handshake flags are registered from the next state
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         cmd_ready <= 1'b0;
         rsp_valid <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         cmd_ready <= (state_nxt == S_IDLE);
         rsp_valid <= (state_nxt == S_RESP);
      end
   end

   // Datapath: ALU drive, response capture and carry flag
   always_ff @(posedge clk) begin
      if (rst) begin
         alu_a      <= '0;
         alu_b      <= '0;
         alu_op     <= '0;
         alu_cin    <= 1'b0;
         rsp_result <= '0;
         rsp_carry  <= 1'b0;
         rsp_zero   <= 1'b0;
         carry_flag <= 1'b0;
      end else begin
         if (accept_c) begin
            alu_a   <= cmd_a;
            alu_b   <= cmd_b;
            alu_op  <= cmd_op;
            alu_cin <= cin_c;
         end
         if (capture_c) begin
            rsp_result <= alu_result;
            rsp_zero   <= (alu_result == '0);
            rsp_carry  <= arith_c & alu_cout;
         end
         // A capture on add/sub takes priority over a simultaneous clear
         if (capture_c && arith_c) carry_flag <= alu_cout;
         else if (flag_clr)        carry_flag <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Scoreboard bench for alu_cmd_issuer: directed corner cases plus random commands,
// with a second instance at SETTLE_CYCLES=4 for latency and mid-transaction reset.
module tb_alu_cmd_issuer;

   localparam int unsigned W  = 32;
   localparam int unsigned W1 = W + 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Main instance (SETTLE_CYCLES = 1)
   logic         rst, cmd_valid, cmd_ready, flag_clr;
   logic [3:0]   cmd_op, alu_op;
   logic [W-1:0] cmd_a, cmd_b, alu_a, alu_b, alu_result, rsp_result;
   logic [1:0]   cmd_cin_sel;
   logic         alu_cin, alu_cout, rsp_valid, rsp_ready, rsp_carry, rsp_zero, carry_flag;

   // Second instance (SETTLE_CYCLES = 4)
   logic         d4_rst, d4_cmd_valid, d4_cmd_ready, d4_flag_clr;
   logic [3:0]   d4_cmd_op, d4_alu_op;
   logic [W-1:0] d4_cmd_a, d4_cmd_b, d4_alu_a, d4_alu_b, d4_alu_result, d4_rsp_result;
   logic [1:0]   d4_cmd_cin_sel;
   logic         d4_alu_cin, d4_alu_cout, d4_rsp_valid, d4_rsp_ready, d4_rsp_carry, d4_rsp_zero;
   logic         d4_carry_flag;

   // Combinational ALU stand-in; non-arithmetic ops drive a junk carry (parity of a)
   function automatic logic [W:0] alu_eval(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [3:0] op, input logic cin);
      case (op)
         4'd0:    return {1'b0, a} + {1'b0, b} + W1'(cin);
         4'd1:    return {1'b0, a} - {1'b0, b} - W1'(cin);
         4'd2:    return {^a, a & b};
         4'd3:    return {^a, a | b};
         4'd4:    return {^a, a ^ b};
         4'd5:    return {^a, ~a};
         4'd6:    return {^a, ~b};
         default: return {^a, a};
      endcase
   endfunction

   assign {alu_cout, alu_result}       = alu_eval(alu_a, alu_b, alu_op, alu_cin);
   assign {d4_alu_cout, d4_alu_result} = alu_eval(d4_alu_a, d4_alu_b, d4_alu_op, d4_alu_cin);

   alu_cmd_issuer #(.WIDTH(W), .SETTLE_CYCLES(1)) u_dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin_sel(cmd_cin_sel), .flag_clr(flag_clr),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
      .alu_result(alu_result), .alu_cout(alu_cout), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_carry(rsp_carry),
      .rsp_zero(rsp_zero), .carry_flag(carry_flag));

   alu_cmd_issuer #(.WIDTH(W), .SETTLE_CYCLES(4)) u_dut4 (
      .clk(clk), .rst(d4_rst), .cmd_valid(d4_cmd_valid), .cmd_ready(d4_cmd_ready),
      .cmd_op(d4_cmd_op), .cmd_a(d4_cmd_a), .cmd_b(d4_cmd_b), .cmd_cin_sel(d4_cmd_cin_sel),
      .flag_clr(d4_flag_clr), .alu_a(d4_alu_a), .alu_b(d4_alu_b), .alu_op(d4_alu_op),
      .alu_cin(d4_alu_cin), .alu_result(d4_alu_result), .alu_cout(d4_alu_cout),
      .rsp_valid(d4_rsp_valid), .rsp_ready(d4_rsp_ready), .rsp_result(d4_rsp_result),
      .rsp_carry(d4_rsp_carry), .rsp_zero(d4_rsp_zero), .carry_flag(d4_carry_flag));

   typedef struct {
      logic [W-1:0] result;
      logic         carry;
      logic         zero;
      logic         flag;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   logic model_flag;
   int   n_cmp = 0;
   int   n_fail = 0;
   int   lat;

   // Reference: integer arithmetic on the command fields and the modelled flag
   function automatic exp_t ref_model(input logic [3:0] op, input logic [W-1:0] a,
                                      input logic [W-1:0] b, input logic [1:0] sel,
                                      input logic flag_in);
      exp_t   e;
      longint s;
      logic   cin;
      cin     = (sel == 2'd1) ? 1'b1 : ((sel == 2'd2) ? flag_in : 1'b0);
      e.carry = 1'b0;
      e.flag  = flag_in;
      case (op)
         4'd0: begin
            s = longint'(a) + longint'(b) + longint'(cin);
            e.result = W'(s);
            e.carry  = (s > longint'(32'hFFFF_FFFF));
            e.flag   = e.carry;
         end
         4'd1: begin
            s = longint'(a) - longint'(b) - longint'(cin);
            e.result = W'(s);
            e.carry  = (s < 0);
            e.flag   = e.carry;
         end
         4'd2:    e.result = a & b;
         4'd3:    e.result = a | b;
         4'd4:    e.result = a ^ b;
         4'd5:    e.result = ~a;
         4'd6:    e.result = ~b;
         default: e.result = a;
      endcase
      e.zero = (e.result == '0);
      return e;
   endfunction

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare every response at its handshake against the scoreboard
   always @(negedge clk) begin
      if (rst === 1'b0 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
         if (sb_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL rsp_unexpected: got result %0h with none outstanding", rsp_result);
         end else begin
            mon_e = sb_q.pop_front();
            check("rsp_result", rsp_result, mon_e.result);
            check1("rsp_carry", rsp_carry, mon_e.carry);
            check1("rsp_zero", rsp_zero, mon_e.zero);
            check1("carry_flag", carry_flag, mon_e.flag);
         end
      end
   end

   // One command through the main instance; stall cycles hold rsp_ready low
   task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [1:0] sel, input int stall, input logic clr_cap,
                       output int l);
      int           n;
      exp_t         e;
      logic [W-1:0] held;
      cmd_op      = op;
      cmd_a       = a;
      cmd_b       = b;
      cmd_cin_sel = sel;
      cmd_valid   = 1'b1;
      rsp_ready   = (stall == 0);
      n = 0;
      while (!cmd_ready && n < 50) begin
         tick();
         n++;
      end
      if (!cmd_ready) begin
         n_cmp++;
         n_fail++;
         $display("FAIL accept_timeout: cmd_ready low for %0d cycles", n);
         cmd_valid = 1'b0;
         l = -1;
         return;
      end
      e = ref_model(op, a, b, sel, model_flag);
      if (clr_cap && op > 4'd1) e.flag = 1'b0;
      model_flag = e.flag;
      sb_q.push_back(e);
      tick();
      cmd_valid = 1'b0;
      flag_clr  = clr_cap;
      l = 0;
      while (rsp_valid !== 1'b1 && l < 40) begin
         tick();
         l++;
         flag_clr = 1'b0;
      end
      flag_clr = 1'b0;
      if (rsp_valid !== 1'b1) begin
         n_cmp++;
         n_fail++;
         $display("FAIL rsp_timeout: no rsp_valid after %0d cycles", l);
         void'(sb_q.pop_back());
         rsp_ready = 1'b1;
         return;
      end
      held = rsp_result;
      for (int i = 0; i < stall; i++) begin
         cmd_valid = (i == 1);
         cmd_a     = ~a;
         tick();
         check1("stall_valid", rsp_valid, 1'b1);
         check("stall_result", rsp_result, held);
         check1("stall_cmd_ready", cmd_ready, 1'b0);
      end
      cmd_valid = 1'b0;
      if (stall > 0) check("alu_a_hold", alu_a, a);
      rsp_ready = 1'b1;
      tick();
   endtask

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_cin_sel = '0;
      flag_clr = 1'b0; rsp_ready = 1'b1; model_flag = 1'b0;
      d4_rst = 1'b1; d4_cmd_valid = 1'b0; d4_cmd_op = '0; d4_cmd_a = '0; d4_cmd_b = '0;
      d4_cmd_cin_sel = '0; d4_flag_clr = 1'b0; d4_rsp_ready = 1'b1;

      // Reset values
      tick();
      tick();
      check1("rst_cmd_ready", cmd_ready, 1'b0);
      check1("rst_rsp_valid", rsp_valid, 1'b0);
      check1("rst_carry_flag", carry_flag, 1'b0);
      check("rst_alu_a", alu_a, '0);
      rst = 1'b0;
      tick();
      check1("post_rst_cmd_ready", cmd_ready, 1'b1);

      // Carry chain: FFFFFFFF+1 then 0+0+flag
      send(4'd0, 32'hFFFF_FFFF, 32'd1, 2'd0, 0, 1'b0, lat);
      check("latency_s1", 32'(lat), 32'd1);
      send(4'd0, 32'd0, 32'd0, 2'd2, 0, 1'b0, lat);
      check1("alu_cin_from_flag", alu_cin, 1'b1);

      // Borrow, then a logic op leaves the flag alone
      send(4'd1, 32'd5, 32'd7, 2'd0, 0, 1'b0, lat);
      send(4'd4, 32'hF0, 32'hFF, 2'd0, 0, 1'b0, lat);

      // Back-pressure with a pulsed cmd_valid, then the next command goes through
      send(4'd2, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 2'd3, 5, 1'b0, lat);
      send(4'd3, 32'h1234_0000, 32'h0000_5678, 2'd1, 0, 1'b0, lat);

      // Clear on the capture edge loses to the capture; pass-through keeps the flag
      send(4'd0, 32'hFFFF_FFFF, 32'd1, 2'd0, 0, 1'b1, lat);
      check1("flag_capture_wins", carry_flag, 1'b1);
      send(4'd9, 32'h1234, 32'd0, 2'd0, 0, 1'b0, lat);
      flag_clr = 1'b1;
      tick();
      flag_clr = 1'b0;
      model_flag = 1'b0;
      check1("flag_clr_idle", carry_flag, 1'b0);

      // Random traffic
      for (int k = 0; k < 150; k++) begin
         logic [W-1:0] ra, rb;
         case ($urandom_range(0, 3))
            0:       ra = '0;
            1:       ra = 32'hFFFF_FFFF;
            default: ra = $urandom;
         endcase
         rb = ($urandom_range(0, 3) == 0) ? 32'd1 : $urandom;
         if ($urandom_range(0, 7) == 0) begin
            flag_clr = 1'b1;
            tick();
            flag_clr = 1'b0;
            model_flag = 1'b0;
         end
         send(4'($urandom_range(0, 15)), ra, rb, 2'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), 1'b0, lat);
      end

      // SETTLE_CYCLES=4 instance: latency, then reset mid-WAIT
      check1("d4_rst_cmd_ready", d4_cmd_ready, 1'b0);
      d4_rst = 1'b0;
      tick();
      check1("d4_post_rst_ready", d4_cmd_ready, 1'b1);
      d4_cmd_op = 4'd0; d4_cmd_a = 32'hFFFF_FFFF; d4_cmd_b = 32'd1; d4_cmd_valid = 1'b1;
      tick();
      d4_cmd_valid = 1'b0;
      lat = 0;
      while (d4_rsp_valid !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
      check("d4_latency", 32'(lat), 32'd4);
      check("d4_result", d4_rsp_result, 32'd0);
      check1("d4_carry", d4_rsp_carry, 1'b1);
      check1("d4_zero", d4_rsp_zero, 1'b1);
      check1("d4_flag", d4_carry_flag, 1'b1);
      tick();
      d4_cmd_a = 32'd3; d4_cmd_b = 32'd4; d4_cmd_valid = 1'b1;
      tick();
      d4_cmd_valid = 1'b0;
      tick();
      tick();
      d4_rst = 1'b1;
      tick();
      check1("d4_midrst_valid", d4_rsp_valid, 1'b0);
      check1("d4_midrst_ready", d4_cmd_ready, 1'b0);
      check1("d4_midrst_flag", d4_carry_flag, 1'b0);
      check("d4_midrst_alu_a", d4_alu_a, '0);
      check("d4_midrst_result", d4_rsp_result, '0);
      tick();
      d4_rst = 1'b0;
      tick();
      check1("d4_ready_after_rst", d4_cmd_ready, 1'b1);
      lat = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (d4_rsp_valid === 1'b1) lat++;
      end
      check("d4_no_rsp_after_rst", 32'(lat), 32'd0);

      check("sb_drain", 32'(sb_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
